// File: rtl/monitor_arb_pkg.sv
// Shared definitions for the monitor RAM arbiter: grant-FSM encoding and Wishbone widths.
package monitor_arb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/monitor_arb_timeout.sv
// Saturating up-counter that bounds how long a granted master may wait for the RAM ack.
module monitor_arb_timeout #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Stops at LAST so a long enable can never wrap back to zero.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count < LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/monitor_arbiter.sv
// Round-robin arbiter sharing the monitor RAM Wishbone slave between the CPU I-bus (m0)
// and D-bus/debug loader (m1), one transaction per grant, with a watchdog error return.
//   state   | meaning
//   ST_IDLE | no grant; bubble between transactions, RAM ack ignored
//   ST_GNT0 | m0 owns the slave port
//   ST_GNT1 | m1 owns the slave port
module monitor_arbiter
    import monitor_arb_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 5,
    parameter int PRIO_INIT = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WB_AW-1:0] m0_adr_i,
    input  logic [WB_DW-1:0] m0_dat_i,
    input  logic [WB_SW-1:0] m0_sel_i,
    input  logic             m0_we_i,
    input  logic             m0_stb_i,
    input  logic             m0_cyc_i,
    output logic [WB_DW-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    input  logic [WB_AW-1:0] m1_adr_i,
    input  logic [WB_DW-1:0] m1_dat_i,
    input  logic [WB_SW-1:0] m1_sel_i,
    input  logic             m1_we_i,
    input  logic             m1_stb_i,
    input  logic             m1_cyc_i,
    output logic [WB_DW-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [WB_AW-1:0] s_adr_o,
    output logic [WB_DW-1:0] s_dat_o,
    output logic [WB_SW-1:0] s_sel_o,
    output logic             s_we_o,
    output logic             s_stb_o,
    output logic             s_cyc_o,
    input  logic [WB_DW-1:0] s_dat_i,
    input  logic             s_ack_i
);

    arb_state_t state;
    logic       prio;
    logic       gnt_sel;
    logic       have_gnt;
    logic       expire;

    logic req0, req1, gnt0, gnt1;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign gnt0 = (state == ST_GNT0);
    assign gnt1 = (state == ST_GNT1);

    monitor_arb_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clr      (state == ST_IDLE),
        .load     (1'b0),
        .load_val ('0),
        .en       (state != ST_IDLE),
        .expire   (expire)
    );

    // Abort (request dropped) returns to idle without touching priority.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            prio     <= 1'(PRIO_INIT);
            gnt_sel  <= 1'b0;
            have_gnt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 && (!req1 || !prio)) begin
                        state    <= ST_GNT0;
                        gnt_sel  <= 1'b0;
                        have_gnt <= 1'b1;
                    end else if (req1) begin
                        state    <= ST_GNT1;
                        gnt_sel  <= 1'b1;
                        have_gnt <= 1'b1;
                    end
                end
                ST_GNT0: begin
                    if (!req0) begin
                        state <= ST_IDLE;
                    end else if (s_ack_i || expire) begin
                        state <= ST_IDLE;
                        prio  <= 1'b1;
                    end
                end
                ST_GNT1: begin
                    if (!req1) begin
                        state <= ST_IDLE;
                    end else if (s_ack_i || expire) begin
                        state <= ST_IDLE;
                        prio  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Address/data keep following the last granted master through the idle bubble.
    assign s_adr_o = gnt_sel ? m1_adr_i : m0_adr_i;
    assign s_dat_o = gnt_sel ? m1_dat_i : m0_dat_i;
    assign s_sel_o = gnt_sel ? m1_sel_i : m0_sel_i;
    assign s_we_o  = have_gnt & (gnt_sel ? m1_we_i : m0_we_i);
    assign s_cyc_o = (gnt0 & req0) | (gnt1 & req1);
    assign s_stb_o = (gnt0 & req0) | (gnt1 & req1);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = gnt0 & req0 & s_ack_i;
    assign m1_ack_o = gnt1 & req1 & s_ack_i;
    assign m0_err_o = gnt0 & req0 & expire & ~s_ack_i;
    assign m1_err_o = gnt1 & req1 & expire & ~s_ack_i;

endmodule
